// File: rtl/cnt_seq_ctrl.sv
// Sequencer for a cascaded up/down/load counter chain: preload, count to all-ones, reload, repeat.
// Latency: mode/data outputs are Moore-decoded from state; tick/done are registered one cycle after the carry edge.
// Backpressure: hold_req freezes the chain (mode hold, no carry-in); stop aborts to IDLE; start is ignored while busy.
module cnt_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int REPW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold_req,
  input  logic [WIDTH-1:0] reload_val,
  input  logic [REPW-1:0]  periods,
  input  logic             cout_in,
  output logic [1:0]       m,
  output logic [WIDTH-1:0] pin,
  output logic             cin,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [REPW-1:0]  period_cnt
);

  // Controller states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Chain mode codes (decrement, code 2, is never issued by this sequencer)
  localparam logic [1:0] M_HOLD = 2'd0;
  localparam logic [1:0] M_INC  = 2'd1;
  localparam logic [1:0] M_LOAD = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_q;

  // State, latched parameters, period counter and the registered tick/done pulses.
  // A period_cnt of zero while running means continuous mode: in counted mode it
  // never reaches zero until the final period ends and the sequencer leaves RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      reload_q   <= '0;
      period_cnt <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            reload_q   <= reload_val;
            period_cnt <= periods;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state      <= S_IDLE;
            period_cnt <= '0;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state      <= S_IDLE;
            period_cnt <= '0;
          end else if (hold_req) begin
            // Chain stays at its value; a pending carry is seen again on resume.
            state <= S_HOLD;
          end else if (cout_in) begin
            tick <= 1'b1;
            if (period_cnt == REPW'(1)) begin
              period_cnt <= '0;
              done       <= 1'b1;
              state      <= S_IDLE;
            end else begin
              if (period_cnt != '0) begin
                period_cnt <= period_cnt - REPW'(1);
              end
              state <= S_LOAD;
            end
          end
        end
        S_HOLD: begin
          if (stop) begin
            state      <= S_IDLE;
            period_cnt <= '0;
          end else if (!hold_req) begin
            state <= S_RUN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the chain interface and busy from the state register.
  always_comb begin
    m    = M_HOLD;
    pin  = '0;
    cin  = 1'b0;
    busy = 1'b0;
    case (state)
      S_LOAD: begin
        m    = M_LOAD;
        pin  = reload_q;
        busy = 1'b1;
      end
      S_RUN: begin
        m    = M_INC;
        cin  = 1'b1;
        busy = 1'b1;
      end
      S_HOLD: begin
        m    = M_HOLD;
        busy = 1'b1;
      end
      default: begin
        m = M_HOLD;
      end
    endcase
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl with a behavioural 8-bit counter chain on the falling edge.
// Expected tick/done cycles are queued when a sequence is started and compared as pulses appear.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_cnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       hold_req;
  logic [7:0] reload_val;
  logic [7:0] periods;
  logic       cout_in;
  logic [1:0] m;
  logic [7:0] pin;
  logic       cin;
  logic       tick;
  logic       done;
  logic       busy;
  logic [7:0] period_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tick_q[$];
  int done_q[$];

  logic [7:0] chain = 8'h00;

  cnt_seq_ctrl #(.WIDTH(8), .REPW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .hold_req   (hold_req),
    .reload_val (reload_val),
    .periods    (periods),
    .cout_in    (cout_in),
    .m          (m),
    .pin        (pin),
    .cin        (cin),
    .tick       (tick),
    .done       (done),
    .busy       (busy),
    .period_cnt (period_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter chain model: updates on the falling edge
  always @(negedge clk) begin
    case (m)
      2'd1: if (cin) chain <= chain + 8'd1;
      2'd2: if (cin) chain <= chain - 8'd1;
      2'd3: chain <= pin;
      default: chain <= chain;
    endcase
  end

  assign cout_in = (chain == 8'hFF) && cin;

  // Scoreboard: every observed pulse must match the next queued cycle
  always @(negedge clk) begin
    int e;
    if (tick === 1'b1) begin
      checks++;
      if (tick_q.size() == 0) begin
        failures++;
        $display("FAIL tick_unexpected cyc=%0d got=1 required=0", cyc);
      end else begin
        e = tick_q.pop_front();
        if (cyc != e) begin
          failures++;
          $display("FAIL tick_cycle got=%0d required=%0d", cyc, e);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cyc=%0d got=1 required=0", cyc);
      end else begin
        e = done_q.pop_front();
        if (cyc != e) begin
          failures++;
          $display("FAIL done_cycle got=%0d required=%0d", cyc, e);
        end
      end
    end
  end

  // Period length in cycles: one LOAD cycle plus the RUN cycles to reach all-ones
  function automatic int period_len(input int r);
    return (r == 255) ? 257 : 1 + (255 - r);
  endfunction

  // Starts a sequence; returns the cycle index at which LOAD is visible
  task automatic do_start(input logic [7:0] r, input logic [7:0] p, output int a);
    @(negedge clk);
    reload_val = r;
    periods    = p;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m, pin, cin, tick, done, busy, period_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=m%0d pin%0h cin%0b tick%0b done%0b busy%0b pc%0d required=all zero",
               m, pin, cin, tick, done, busy, period_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_counted;
    int a;
    logic [1:0] exp_m  [9] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0};
    logic [7:0] exp_pc [9] = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};
    logic       exp_b  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_start(8'hFC, 8'd2, a);
    tick_q.push_back(a + 4);
    tick_q.push_back(a + 8);
    done_q.push_back(a + 8);
    checks++;
    if (pin !== 8'hFC || cin !== 1'b0) begin
      failures++;
      $display("FAIL load_pin_cin got=%0h/%0b required=fc/0", pin, cin);
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (m !== exp_m[i] || period_cnt !== exp_pc[i] || busy !== exp_b[i]) begin
        failures++;
        $display("FAIL counted_step%0d got=m%0d pc%0d busy%0b required=m%0d pc%0d busy%0b",
                 i, m, period_cnt, busy, exp_m[i], exp_pc[i], exp_b[i]);
      end
      if (i == 1) begin
        checks++;
        if (pin !== 8'h00 || cin !== 1'b1) begin
          failures++;
          $display("FAIL run_pin_cin got=%0h/%0b required=00/1", pin, cin);
        end
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL counted_pending got=%0d/%0d required=0/0", tick_q.size(), done_q.size());
    end
  endtask

  task automatic test_continuous;
    int a;
    do_start(8'hF0, 8'd0, a);
    for (int k = 1; k <= 5; k++) tick_q.push_back(a + 16 * k);
    while (cyc < a + 80) begin
      if ((cyc - a) % 16 == 7) begin
        checks++;
        if (period_cnt !== 8'd0 || busy !== 1'b1) begin
          failures++;
          $display("FAIL cont_pc got=%0d/%0b required=0/1", period_cnt, busy);
        end
      end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (m !== 2'd0 || busy !== 1'b0 || period_cnt !== 8'd0) begin
      failures++;
      $display("FAIL cont_stop got=m%0d busy%0b pc%0d required=m0 busy0 pc0", m, busy, period_cnt);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL cont_pending got=%0d/%0d required=0/0", tick_q.size(), done_q.size());
    end
  endtask

  task automatic test_hold;
    int a;
    do_start(8'h00, 8'd1, a);
    tick_q.push_back(a + period_len(0) + 5);
    done_q.push_back(a + period_len(0) + 5);
    wait_until(a + 50);
    hold_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (m !== 2'd0 || cin !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_outputs step%0d got=m%0d cin%0b busy%0b required=m0 cin0 busy1", i, m, cin, busy);
      end
    end
    hold_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m !== 2'd1 || cin !== 1'b1) begin
      failures++;
      $display("FAIL hold_resume got=m%0d cin%0b required=m1 cin1", m, cin);
    end
    wait_until(a + 266);
    checks++;
    if (tick_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_pending got=%0d/%0d busy%0b required=0/0 busy0", tick_q.size(), done_q.size(), busy);
    end
  endtask

  task automatic test_wrap;
    int a;
    do_start(8'hFF, 8'd1, a);
    tick_q.push_back(a + 257);
    done_q.push_back(a + 257);
    wait_until(a + 262);
    checks++;
    if (tick_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_pending got=%0d/%0d required=0/0", tick_q.size(), done_q.size());
    end
  endtask

  task automatic test_start_busy_and_reset;
    int a;
    do_start(8'hFC, 8'd3, a);
    for (int k = 1; k <= 3; k++) tick_q.push_back(a + 4 * k);
    done_q.push_back(a + 12);
    wait_until(a + 2);
    reload_val = 8'h10;
    periods    = 8'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(a + 5);
    checks++;
    if (period_cnt !== 8'd2 || pin !== 8'h00) begin
      failures++;
      $display("FAIL start_ignored got=pc%0d pin%0h required=pc2 pin00", period_cnt, pin);
    end
    wait_until(a + 8);
    checks++;
    if (m !== 2'd3 || pin !== 8'hFC) begin
      failures++;
      $display("FAIL reload_kept got=m%0d pin%0h required=m3 pinfc", m, pin);
    end
    wait_until(a + 15);
    checks++;
    if (tick_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_pending got=%0d/%0d busy%0b required=0/0 busy0", tick_q.size(), done_q.size(), busy);
    end
    do_start(8'h80, 8'd5, a);
    wait_until(a + 20);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({m, pin, cin, tick, done, busy, period_cnt} !== '0) begin
      failures++;
      $display("FAIL midrun_reset got=m%0d pin%0h cin%0b tick%0b done%0b busy%0b pc%0d required=all zero",
               m, pin, cin, tick, done, busy, period_cnt);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_stop_vs_carry;
    int a;
    do_start(8'hFC, 8'd2, a);
    wait_until(a + 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (m !== 2'd0 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0 || period_cnt !== 8'd0) begin
      failures++;
      $display("FAIL stop_carry got=m%0d busy%0b tick%0b done%0b pc%0d required=all zero",
               m, busy, tick, done, period_cnt);
    end
    repeat (4) @(negedge clk);
    do_start(8'hFE, 8'd1, a);
    tick_q.push_back(a + 2);
    done_q.push_back(a + 2);
    checks++;
    if (m !== 2'd3 || pin !== 8'hFE) begin
      failures++;
      $display("FAIL restart_load got=m%0d pin%0h required=m3 pinfe", m, pin);
    end
    wait_until(a + 2);
    checks++;
    if (m !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_end got=m%0d busy%0b required=m0 busy0", m, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (tick_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL restart_pending got=%0d/%0d required=0/0", tick_q.size(), done_q.size());
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    hold_req   = 1'b0;
    reload_val = 8'h00;
    periods    = 8'd0;
    test_reset;
    test_counted;
    test_continuous;
    test_hold;
    test_wrap;
    test_start_busy_and_reset;
    test_stop_vs_carry;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
